// File: rtl/servo_pkg.sv
// servo_pkg: shared types, default timing constants and the width clamp
// used by the servo PWM scheduler.
//   state_t     - frame sequencer states (IDLE, LOAD, RUN)
//   pulse_t     - 16-bit pulse width in timebase ticks
//   ch_idx_t    - 3-bit channel index as carried on the command bus
//   clamp_width - unsigned clamp of a requested width into [lo, hi]
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef logic [15:0] pulse_t;
  typedef logic [2:0]  ch_idx_t;

  // Defaults: 100 MHz clock, 1 us tick, 20 ms frame, 1.0..2.0 ms pulses.
  localparam int CLK_HZ_DEFAULT    = 100_000_000;
  localparam int TICK_HZ_DEFAULT   = 1_000_000;
  localparam int N_CH_DEFAULT      = 4;
  localparam int FRAME_US_DEFAULT  = 20000;
  localparam int MIN_US_DEFAULT    = 1000;
  localparam int MAX_US_DEFAULT    = 2000;
  localparam int CENTER_US_DEFAULT = 1500;

  function automatic pulse_t clamp_width(input pulse_t w, input pulse_t lo, input pulse_t hi);
    pulse_t result;
    result = w;
    if (w < lo) begin
      result = lo;
    end else if (w > hi) begin
      result = hi;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-clk tick every DIV clocks.
//   clk   - system clock
//   rst   - synchronous, active-high reset
//   clear - forces the prescaler to 0 (held while the sequencer is not running)
//   tick  - high on the last clock of each DIV-clock period
module tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt_reg;
  logic [PW-1:0] pre_cnt_next;

  always_comb begin
    pre_cnt_next = pre_cnt_reg + PW'(1);
    if (clear || (pre_cnt_reg == PRE_LAST)) begin
      pre_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

  assign tick = (pre_cnt_reg == PRE_LAST);

endmodule

// File: rtl/servo_pwm_scheduler.sv
// servo_pwm_scheduler: multi-channel servo PWM frame sequencer.
// Commands land in per-channel shadow registers; shadows are copied into
// the active set only in the single LOAD cycle at each frame boundary, so
// a pulse in progress is never altered.
//   clk, rst        - system clock, synchronous active-high reset
//   enable          - run request; a frame in progress always completes
//   cmd_valid/ready - command handshake (ready low in reset and in LOAD)
//   cmd_ch/en/width - target channel, output enable, requested width (ticks)
//   cmd_err         - one-cycle pulse after accepting a command for cmd_ch >= N_CH
//   pwm_out         - registered servo pulse outputs
//   frame_start     - high during the LOAD cycle
//   running         - high in LOAD and RUN
module servo_pwm_scheduler
  import servo_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEFAULT,
  parameter int TICK_HZ   = TICK_HZ_DEFAULT,
  parameter int N_CH      = N_CH_DEFAULT,
  parameter int FRAME_US  = FRAME_US_DEFAULT,
  parameter int MIN_US    = MIN_US_DEFAULT,
  parameter int MAX_US    = MAX_US_DEFAULT,
  parameter int CENTER_US = CENTER_US_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_ch,
  input  logic            cmd_en,
  input  logic [15:0]     cmd_width,
  output logic            cmd_err,
  output logic [N_CH-1:0] pwm_out,
  output logic            frame_start,
  output logic            running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int UCW = $clog2(FRAME_US);
  localparam logic [UCW-1:0] US_LAST = UCW'(FRAME_US - 1);
  localparam pulse_t MIN_W    = pulse_t'(MIN_US);
  localparam pulse_t MAX_W    = pulse_t'(MAX_US);
  localparam pulse_t CENTER_W = pulse_t'(CENTER_US);

  state_t         state_reg;
  logic [UCW-1:0] us_cnt_reg;
  logic           frame_start_reg;
  logic           running_reg;
  logic           cmd_err_reg;

  pulse_t width_shadow_reg [N_CH];
  logic   en_shadow_reg    [N_CH];
  pulse_t width_act_reg    [N_CH];
  logic   en_act_reg       [N_CH];
  logic   pwm_reg          [N_CH];

  logic   tick;
  logic   cmd_accept;
  logic   cmd_bad_ch;
  pulse_t cmd_width_clamped;

  // Prescaler only free-runs in RUN so every frame starts with a full tick.
  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(state_reg != RUN),
    .tick (tick)
  );

  // LOAD is the only cycle that reads the shadows, so refuse writes there.
  assign cmd_ready         = !rst && (state_reg != LOAD);
  assign cmd_accept        = cmd_valid && cmd_ready;
  assign cmd_bad_ch        = ({1'b0, cmd_ch} >= 4'(N_CH));
  assign cmd_width_clamped = clamp_width(cmd_width, MIN_W, MAX_W);

  // Frame sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      us_cnt_reg      <= '0;
      frame_start_reg <= 1'b0;
      running_reg     <= 1'b0;
      cmd_err_reg     <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      cmd_err_reg     <= cmd_accept && cmd_bad_ch;
      case (state_reg)
        IDLE: begin
          us_cnt_reg  <= '0;
          running_reg <= 1'b0;
          if (enable) begin
            state_reg       <= LOAD;
            frame_start_reg <= 1'b1;
            running_reg     <= 1'b1;
          end
        end
        LOAD: begin
          us_cnt_reg  <= '0;
          running_reg <= 1'b1;
          state_reg   <= RUN;
        end
        RUN: begin
          if (tick) begin
            if (us_cnt_reg == US_LAST) begin
              us_cnt_reg <= '0;
              if (enable) begin
                state_reg       <= LOAD;
                frame_start_reg <= 1'b1;
              end else begin
                state_reg   <= IDLE;
                running_reg <= 1'b0;
              end
            end else begin
              us_cnt_reg <= us_cnt_reg + UCW'(1);
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel shadow, active and pulse registers.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst) begin
        width_shadow_reg[gi] <= CENTER_W;
        en_shadow_reg[gi]    <= 1'b0;
        width_act_reg[gi]    <= CENTER_W;
        en_act_reg[gi]       <= 1'b0;
        pwm_reg[gi]          <= 1'b0;
      end else begin
        if (cmd_accept && (cmd_ch == ch_idx_t'(gi))) begin
          width_shadow_reg[gi] <= cmd_width_clamped;
          en_shadow_reg[gi]    <= cmd_en;
        end
        if (state_reg == LOAD) begin
          width_act_reg[gi] <= width_shadow_reg[gi];
          en_act_reg[gi]    <= en_shadow_reg[gi];
        end
        // High for us_cnt 0..width-1, i.e. exactly width ticks, one clk late.
        pwm_reg[gi] <= (state_reg == RUN) && en_act_reg[gi] &&
                       (32'(us_cnt_reg) < 32'(width_act_reg[gi]));
      end
    end
    assign pwm_out[gi] = pwm_reg[gi];
  end

  assign frame_start = frame_start_reg;
  assign running     = running_reg;
  assign cmd_err     = cmd_err_reg;

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Scoreboard bench for servo_pwm_scheduler (DIV=10, FRAME_US=50, MIN/MAX 5/20,
// CENTER 12, 4 channels). A behavioural shadow/active model queues the pulse
// lengths expected for each frame; a negedge monitor measures pulses and
// frame timing and retires queue entries.
module tb_servo_pwm_scheduler;

  localparam int N_CH      = 4;
  localparam int DIV       = 10;
  localparam int FRAME_US  = 50;
  localparam int MIN_US    = 5;
  localparam int MAX_US    = 20;
  localparam int CENTER_US = 12;
  localparam int FRAME_CLK = FRAME_US * DIV + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_ch;
  logic            cmd_en;
  logic [15:0]     cmd_width;
  logic            cmd_err;
  logic [N_CH-1:0] pwm_out;
  logic            frame_start;
  logic            running;

  servo_pwm_scheduler #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .N_CH     (N_CH),
    .FRAME_US (FRAME_US),
    .MIN_US   (MIN_US),
    .MAX_US   (MAX_US),
    .CENTER_US(CENTER_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_en     (cmd_en),
    .cmd_width  (cmd_width),
    .cmd_err    (cmd_err),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .running    (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model
  typedef struct {
    int ch;
    int len;
  } pulse_exp_t;

  pulse_exp_t exp_q[$];
  int         err_q[$];
  int         sh_w   [N_CH];
  bit         sh_en  [N_CH];
  int         act_w  [N_CH];
  bit         act_en [N_CH];

  function automatic int model_clamp(input int w);
    if (w < MIN_US) return MIN_US;
    if (w > MAX_US) return MAX_US;
    return w;
  endfunction

  // Monitor
  bit in_pulse [N_CH];
  int run_len  [N_CH];
  int want_len [N_CH];
  int fs_cyc   = 0;
  int last_fs  = -1;
  int fs_count = 0;
  int mon_idx;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_fs = -1;
      for (int c = 0; c < N_CH; c++) begin
        sh_w[c] = CENTER_US; sh_en[c] = 1'b0;
        act_w[c] = CENTER_US; act_en[c] = 1'b0;
        in_pulse[c] = 1'b0; run_len[c] = 0; want_len[c] = -1;
      end
    end else begin
      if (frame_start) begin
        fs_count++;
        if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME_CLK);
        check("pulses_done_at_frame", exp_q.size(), 0);
        last_fs = cyc;
        fs_cyc  = cyc;
        for (int c = 0; c < N_CH; c++) begin
          act_w[c]  = sh_w[c];
          act_en[c] = sh_en[c];
          if (act_en[c]) exp_q.push_back('{ch: c, len: act_w[c] * DIV});
        end
      end
      if (!running) last_fs = -1;
      for (int c = 0; c < N_CH; c++) begin
        if (pwm_out[c] && !in_pulse[c]) begin
          in_pulse[c] = 1'b1;
          run_len[c]  = 1;
          check($sformatf("rise_lag_ch%0d", c), cyc - fs_cyc, 2);
          mon_idx = -1;
          foreach (exp_q[k]) if (mon_idx < 0 && exp_q[k].ch == c) mon_idx = k;
          check($sformatf("pulse_expected_ch%0d", c), (mon_idx >= 0) ? 1 : 0, 1);
          if (mon_idx >= 0) begin
            want_len[c] = exp_q[mon_idx].len;
            exp_q.delete(mon_idx);
          end else begin
            want_len[c] = -1;
          end
        end else if (pwm_out[c] && in_pulse[c]) begin
          run_len[c]++;
        end else if (!pwm_out[c] && in_pulse[c]) begin
          in_pulse[c] = 1'b0;
          $display("pulse ch%0d len=%0d clk", c, run_len[c]);
          check($sformatf("pulse_len_ch%0d", c), run_len[c], want_len[c]);
        end
      end
      if (cmd_err) begin
        if (err_q.size() == 0) check("cmd_err_unexpected", 1, 0);
        else check("cmd_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // Stimulus helpers (all entered and left at a negedge)
  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2000);
    if (!frame_start) check("frame_start_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int at_cyc);
    int n;
    n = 0;
    while (running && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (running) check("idle_timeout", 0, 1);
    at_cyc = cyc;
  endtask

  task automatic send(input int ch, input bit en, input int w, output int stalls);
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_en    = en;
    cmd_width = 16'(w);
    stalls    = 0;
    while (!cmd_ready && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 0, 1);
    end else begin
      $display("cmd ch=%0d en=%0d width=%0d accepted cycle=%0d stalls=%0d",
               ch, en, w, cyc, stalls);
      if (ch < N_CH) begin
        sh_w[ch]  = model_clamp(w);
        sh_en[ch] = en;
      end else begin
        err_q.push_back(cyc + 1);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int stalls;
  int load_cyc;
  int idle_cyc;
  int fs_before;

  initial begin
    rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0;
    cmd_ch = '0; cmd_en = 1'b0; cmd_width = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_running", running, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;

    // No commands: frames run, all outputs disabled.
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    enable = 1'b1;
    wait_fs();
    @(negedge clk);
    check("running_after_load", running, 1);
    repeat (40) @(negedge clk);
    check("pwm_all_disabled", pwm_out, 0);
    wait_fs();
    wait_fs();
    enable = 1'b0;
    wait_idle(idle_cyc);

    // Configure in IDLE, then run.
    send(0, 1'b1, 8, stalls);
    send(2, 1'b1, 15, stalls);
    enable = 1'b1;
    wait_fs();

    // Clamp floor, ceiling and an out-of-range channel.
    send(1, 1'b1, 2, stalls);
    wait_fs();
    send(1, 1'b1, 300, stalls);
    send(5, 1'b1, 9, stalls);
    wait_fs();

    // Mid-frame update at us_cnt=3 only affects the next frame.
    repeat (33) @(negedge clk);
    send(0, 1'b1, 18, stalls);
    wait_fs();

    // Command presented during LOAD stalls exactly one cycle.
    check("ready_in_load", cmd_ready, 0);
    send(3, 1'b1, 10, stalls);
    check("load_stall_cycles", stalls, 1);
    wait_fs();

    // Drop enable at us_cnt=2: frame completes, then IDLE.
    load_cyc = cyc;
    repeat (22) @(negedge clk);
    enable = 1'b0;
    wait_idle(idle_cyc);
    check("idle_after_full_frame", idle_cyc - load_cyc, FRAME_CLK);
    fs_before = fs_count;
    repeat (600) @(negedge clk);
    check("no_frame_start_in_idle", fs_count - fs_before, 0);
    check("idle_running", running, 0);

    // Reset in the middle of the pulses.
    enable = 1'b1;
    wait_fs();
    repeat (20) @(negedge clk);
    check("pwm_before_rst", pwm_out, 15);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm_out", pwm_out, 0);
    check("rst_mid_running", running, 0);
    check("rst_mid_frame_start", frame_start, 0);
    check("rst_mid_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Shadows were lost: frames run with every output disabled.
    wait_fs();
    repeat (30) @(negedge clk);
    check("pwm_after_rst_cleared", pwm_out, 0);
    wait_fs();
    enable = 1'b0;
    wait_idle(idle_cyc);
    check("pending_pulses_at_end", exp_q.size(), 0);
    check("pending_cmd_err_at_end", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_scheduler.md
Name: servo_pwm_scheduler

Overview:
Multi-channel servo PWM controller for the Basys3 servo/SPI steering design. An internal prescaler divides clk into a 1 µs timebase, and the block sequences fixed-length servo frames (20 ms by default) from that timebase. It accepts per-channel pulse-width commands from the SPI command decoder over a valid/ready handshake and buffers them in shadow registers. Shadow values are applied only at frame boundaries, so servo pulses are never glitched or truncated.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
TICK_HZ, 1_000_000, timebase rate; DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2
N_CH, 4, number of servo channels (1..8)
FRAME_US, 20000, frame length in ticks
MIN_US, 1000, minimum pulse width in ticks (clamp floor)
MAX_US, 2000, maximum pulse width in ticks (clamp ceiling); MAX_US < FRAME_US
CENTER_US, 1500, reset value of every width register

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run request for frame generation
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted this cycle
cmd_ch  in  3  target channel index
cmd_en  in  1  channel output enable
cmd_width  in  16  requested pulse width in ticks
cmd_err  out  1  one-cycle pulse when an accepted command names cmd_ch ≥ N_CH
pwm_out  out  N_CH  servo pulse outputs
frame_start  out  1  one-cycle pulse on every LOAD cycle
running  out  1  high while in LOAD or RUN

Behaviour:
- Reset values: pwm_out=0, frame_start=0, cmd_err=0, running=0, cmd_ready=0 while rst is high. All shadow and active widths reset to CENTER_US. All shadow and active enables reset to 0. Prescaler and us_cnt reset to 0. FSM resets to IDLE.
- Prescaler: pre_cnt counts 0..DIV-1 and wraps. tick=1 when pre_cnt==DIV-1. In IDLE, pre_cnt is held at 0.
- us_cnt: range 0..FRAME_US-1. Increments on tick in RUN only.
- FSM states: IDLE, LOAD, RUN.
- IDLE: pwm_out=0, us_cnt=0. Moves to LOAD when enable=1.
- LOAD (exactly 1 cycle):
  - active widths/enables ← shadow.
  - us_cnt=0, pre_cnt=0, frame_start=1, cmd_ready=0.
  - Always moves to RUN.
- RUN:
  - pwm_out[i] is registered: pwm_out[i] ← en_act[i] && (us_cnt < width_act[i]). Each pulse is therefore exactly width_act[i] ticks long and lags us_cnt by one clk.
  - Frame end is the cycle where tick && us_cnt==FRAME_US-1.
  - At frame end: go to LOAD if enable=1, otherwise to IDLE.
  - Dropping enable mid-frame always completes the current frame; pulses are never truncated.
- Handshake:
  - cmd_ready=1 in IDLE and RUN (not in reset, not in LOAD).
  - A command is accepted when cmd_valid && cmd_ready. On acceptance: shadow_w[cmd_ch] ← clamp(cmd_width, MIN_US, MAX_US) and shadow_en[cmd_ch] ← cmd_en.
  - If cmd_ch ≥ N_CH: the command is accepted and discarded, and cmd_err pulses for one cycle on the following cycle.
- Boundary conditions:
  - A command accepted on the cycle before LOAD takes effect in that LOAD.
  - A command held valid during LOAD stalls one cycle and is accepted in the first RUN cycle, so it applies at the next frame.
  - Multiple writes to the same channel within one frame: the last write wins.
  - Active registers never change except in LOAD.
- rst mid-frame: every output drops to its reset value on the next clk edge, and all shadow contents are lost.
- Width arithmetic: clamp is unsigned 16-bit. us_cnt width is $clog2(FRAME_US).

Decomposition:
- servo_pkg holds:
  - typedef state_t {IDLE, LOAD, RUN}
  - typedef pulse_t (logic [15:0])
  - typedef ch_idx_t (logic [2:0])
  - function clamp_width
  - default timing constants
- Sub-module tick_gen(DIV): prescaler with clear input (hold at 0 in IDLE, zero in LOAD) and tick output.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), FRAME_US=50, MIN_US=5, MAX_US=20, CENTER_US=12, N_CH=4.
- Reset then enable=1 with no commands:
  - frame_start pulses, running=1, pwm_out stays 0 (all enables 0).
  - Next frame_start arrives exactly 501 clk later (500 RUN cycles + 1 LOAD).
- Write ch0 en=1 width=8 and ch2 en=1 width=15 in IDLE, then enable:
  - pwm_out[0] is high for 80 clk and pwm_out[2] for 150 clk, both rising together one clk after LOAD.
- Clamp and error:
  - ch1 width=2 → 50 clk pulse; ch1 width=300 → 200 clk pulse.
  - cmd_ch=5 → cmd_err pulses for 1 cycle and no pwm change.
- Mid-frame update: write ch0 width=18 at us_cnt=3 while the active width is 8 → current frame pulse stays 80 clk, next frame pulse is 180 clk.
- cmd_valid held across LOAD → cmd_ready=0 for exactly 1 cycle, then the command is accepted and applies one frame later.
- enable dropped at us_cnt=2 → the frame completes, then IDLE with running=0 and no further frame_start.
- rst asserted mid-pulse → pwm_out=0 on the next edge.
